bin2bcd_seq: RTL and testbench

Sequential binary-to-BCD converter that sits directly upstream of the 4-digit seven-segment driver. It takes an unsigned binary value from the datapath or debug path, such as a register, PC or cycle count, and converts it to four decimal digits with the shift-add-3 (double-dabble) algorithm, one input bit per clock. The four BCD outputs connect straight to the driver's `in3..in0` inputs and hold the last result between conversions. A start/busy/done handshake lets the display-update logic request a new conversion at any rate.

---
 rtl/bin2bcd_seq.sv | 155 +++++++++++++++
 tb/tb_bin2bcd_seq.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential binary-to-BCD converter (shift-add-3 / double-dabble).
//
// Converts an unsigned WIDTH-bit value into four BCD digits, one input bit per
// clock, for the 4-digit seven-segment driver. Values above 9999 saturate the
// display to 9999 and raise overflow. Results hold between conversions.
//
// Ports:
//   clk       in   system clock
//   reset_n   in   asynchronous active-low reset
//   start     in   conversion request, accepted only while idle
//   bin       in   value to convert, captured on the accepting edge
//   busy      out  high while a conversion is in progress
//   done      out  one-cycle pulse when new results are presented
//   overflow  out  last converted value was greater than 9999
//   bcd3..0   out  thousands / hundreds / tens / units digits
//
// Timing: start accepted on edge E0, shifts on E1..E(WIDTH), results and the
// done pulse on E(WIDTH+1). Back-to-back throughput is one per WIDTH+2 cycles.
// All outputs come straight from flops.

module bin2bcd_seq #(
    parameter int unsigned WIDTH = 14
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] bin,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic [3:0]       bcd3,
    output logic [3:0]       bcd2,
    output logic [3:0]       bcd1,
    output logic [3:0]       bcd0
);

    // Five BCD digits cover the full 16-bit input range (65535).
    localparam int unsigned ScratchW = 20;
    localparam int unsigned CntW     = 5;
    localparam int unsigned CombW    = ScratchW + WIDTH;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [WIDTH-1:0]      shift_q, shift_d;
    logic [ScratchW-1:0]   scratch_q, scratch_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  ovf_q, ovf_d;
    logic [15:0]           bcd_q, bcd_d;

    // Add-3 correction and the one-bit shift of the combined vector.
    logic [ScratchW-1:0]   scratch_adj;
    logic [CombW-1:0]      comb_vec;
    logic [CombW-1:0]      comb_shl;

    always_comb begin
        scratch_adj = scratch_q;
        for (int i = 0; i < 5; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) begin
                scratch_adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
            end
        end
        comb_vec = {scratch_adj, shift_q};
        comb_shl = comb_vec << 1;
    end

    // Next-state and output logic.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        ovf_d     = ovf_q;
        bcd_d     = bcd_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    shift_d   = bin;
                    scratch_d = '0;
                    cnt_d     = CntW'(WIDTH);
                    state_d   = StShift;
                end
            end

            StShift: begin
                scratch_d = comb_shl[WIDTH +: ScratchW];
                shift_d   = comb_shl[WIDTH-1:0];
                cnt_d     = cnt_q - CntW'(1);
                if (cnt_d == '0) begin
                    state_d = StDone;
                end
            end

            StDone: begin
                done_d  = 1'b1;
                state_d = StIdle;
                // A nonzero ten-thousands digit cannot be shown: saturate.
                if (scratch_q[19:16] != 4'd0) begin
                    ovf_d = 1'b1;
                    bcd_d = 16'h9999;
                end else begin
                    ovf_d = 1'b0;
                    bcd_d = scratch_q[15:0];
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        // Registered busy mirrors the state being entered, so it drops on the
        // same edge that raises done.
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            shift_q   <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
            bcd_q     <= '0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
            bcd_q     <= bcd_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign overflow = ovf_q;
    assign bcd3     = bcd_q[15:12];
    assign bcd2     = bcd_q[11:8];
    assign bcd1     = bcd_q[7:4];
    assign bcd0     = bcd_q[3:0];

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Testbench for bin2bcd_seq: table of known conversions, hand-written
// sequences for busy/back-to-back/reset behaviour, then random values checked
// against an arithmetic decimal-digit model.

module tb_bin2bcd_seq;

    localparam int W = 14;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] bin = '0;
    logic         busy;
    logic         done;
    logic         overflow;
    logic [3:0]   bcd3, bcd2, bcd1, bcd0;

    int n_vec = 0;
    int n_miss = 0;
    int done_count = 0;
    int cyc_cnt = 0;

    always #5 clk = ~clk;

    bin2bcd_seq #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .bin      (bin),
        .busy     (busy),
        .done     (done),
        .overflow (overflow),
        .bcd3     (bcd3),
        .bcd2     (bcd2),
        .bcd1     (bcd1),
        .bcd0     (bcd0)
    );

    typedef struct {
        logic [W-1:0] bin;
        logic [15:0]  bcd;
        logic         ovf;
    } vec_t;

    vec_t tbl[12];

    // Expected {overflow, d3, d2, d1, d0} from plain decimal arithmetic.
    function automatic logic [16:0] ref_model(input int unsigned v);
        if (v > 9999) return {1'b1, 16'h9999};
        return {1'b0, 4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [16:0] outs();
        return {overflow, bcd3, bcd2, bcd1, bcd0};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc_cnt++;

    // Outputs may only move on a done cycle (or under reset); also counts pulses.
    logic [16:0] prev_out;
    logic        hold_ok = 1'b0;
    always @(negedge clk) begin
        if (!reset_n) begin
            hold_ok = 1'b0;
        end else begin
            if (done) begin
                done_count++;
            end else if (hold_ok && outs() !== prev_out) begin
                n_miss++;
                $display("FAIL hold: outputs 0x%0h changed from 0x%0h without done",
                         outs(), prev_out);
            end
            prev_out = outs();
            hold_ok  = 1'b1;
        end
    end

    // Wait (bounded) for done; called at a negedge.
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    // One full conversion starting from idle at a negedge.
    task automatic do_conv(input logic [W-1:0] v, input logic [16:0] exp, input string tag);
        int cyc;
        int bcnt;
        start = 1'b1;
        bin   = v;
        @(negedge clk);
        start = 1'b0;
        bin   = ~v;
        cyc   = 0;
        bcnt  = 0;
        while (!done && cyc < 40) begin
            if (busy) bcnt++;
            @(negedge clk);
            cyc++;
        end
        chk({tag, " latency"}, cyc, W + 1);
        chk({tag, " busy cycles"}, bcnt, W + 1);
        chk({tag, " busy at done"}, 32'(busy), 0);
        chk({tag, " result"}, 32'(outs()), 32'(exp));
        @(negedge clk);
        chk({tag, " done width"}, 32'(done), 0);
    endtask

    initial begin
        int cyc;
        int base;
        int t_prev;
        int unsigned v;

        tbl[0]  = '{14'd1234,  16'h1234, 1'b0};
        tbl[1]  = '{14'd0,     16'h0000, 1'b0};
        tbl[2]  = '{14'd9999,  16'h9999, 1'b0};
        tbl[3]  = '{14'd10000, 16'h9999, 1'b1};
        tbl[4]  = '{14'd16383, 16'h9999, 1'b1};
        tbl[5]  = '{14'd1,     16'h0001, 1'b0};
        tbl[6]  = '{14'd10,    16'h0010, 1'b0};
        tbl[7]  = '{14'd99,    16'h0099, 1'b0};
        tbl[8]  = '{14'd100,   16'h0100, 1'b0};
        tbl[9]  = '{14'd5000,  16'h5000, 1'b0};
        tbl[10] = '{14'd8191,  16'h8191, 1'b0};
        tbl[11] = '{14'd9998,  16'h9998, 1'b0};

        // Reset state.
        repeat (3) @(negedge clk);
        chk("reset busy", 32'(busy), 0);
        chk("reset done", 32'(done), 0);
        chk("reset outputs", 32'(outs()), 0);
        reset_n = 1'b1;

        // Table: first request on the very first edge after release.
        foreach (tbl[i]) begin
            do_conv(tbl[i].bin, {tbl[i].ovf, tbl[i].bcd}, $sformatf("table[%0d]", i));
        end

        // start during busy is dropped, not queued.
        base  = done_count;
        start = 1'b1;
        bin   = 14'd42;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1;
        bin   = 14'd777;
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc);
        chk("busy-ignore done seen", 32'(done), 1);
        chk("busy-ignore result", 32'(outs()), 32'(17'h00042));
        repeat (25) @(negedge clk);
        chk("busy-ignore done count", done_count - base, 1);
        chk("busy-ignore result held", 32'(outs()), 32'(17'h00042));

        // start held high: one conversion every W+2 cycles.
        start  = 1'b1;
        bin    = 14'd56;
        t_prev = 0;
        for (int k = 0; k < 3; k++) begin
            wait_done(cyc);
            chk("hold-start done seen", 32'(done), 1);
            chk("hold-start result", 32'(outs()), 32'(17'h00056));
            if (k > 0) chk("hold-start spacing", cyc_cnt - t_prev, W + 2);
            t_prev = cyc_cnt;
            @(negedge clk);
        end
        start = 1'b0;
        repeat (20) @(negedge clk);

        // bin changed one cycle after capture must not matter.
        start = 1'b1;
        bin   = 14'd1000;
        @(negedge clk);
        start = 1'b0;
        bin   = 14'd2000;
        wait_done(cyc);
        chk("late-bin done seen", 32'(done), 1);
        chk("late-bin result", 32'(outs()), 32'(17'h01000));
        @(negedge clk);

        // Reset in the middle of a conversion.
        do_conv(14'd4321, {1'b0, 16'h4321}, "pre-reset");
        base  = done_count;
        start = 1'b1;
        bin   = 14'd8888;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("mid-reset busy", 32'(busy), 0);
        chk("mid-reset done", 32'(done), 0);
        chk("mid-reset outputs", 32'(outs()), 0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("mid-reset no done", done_count - base, 0);
        chk("mid-reset outputs stay cleared", 32'(outs()), 0);

        // Random values against the arithmetic model.
        for (int k = 0; k < 500; k++) begin
            v = $urandom_range(0, 16383);
            do_conv(v[W-1:0], ref_model(v), $sformatf("rand %0d", v));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", n_miss);
        $fatal(1, "watchdog expired");
    end

endmodule
